regfile_writeport: RTL and testbench

- Four-entry, 8-bit general register file (A, B, C, D) for the i281 datapath.
- Write side accepts the result from the ALU/memory write-back mux.
- Read side drives the left and right operand buses (reginputleft, reginputright) into the left and right input registers.
- Provides same-cycle write-to-read forwarding, so an input register loading on its read-select strobe captures the value being written that cycle.
- Also exports a packed register dump and per-register "written since reset" flags for the display/debug path.

---
 rtl/i281_pkg.sv | 14 +
 rtl/regfile_readmux.sv | 25 ++
 rtl/regfile_writeport.sv | 77 +++++++
 tb/tb_regfile_writeport.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/i281_pkg.sv
// Shared i281 datapath definitions: data/select widths and register indices.
package i281_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_SEL_W = 2;

    typedef enum logic [REG_SEL_W-1:0] {
        REG_A = 2'd0,
        REG_B = 2'd1,
        REG_C = 2'd2,
        REG_D = 2'd3
    } reg_idx_t;

endpackage

// File: rtl/regfile_readmux.sv
// Combinational register read port with same-cycle write-to-read forwarding.
module regfile_readmux
    import i281_pkg::*;
#(
    parameter int unsigned WIDTH    = DATA_W,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS*WIDTH-1:0] regs,
    input  logic [SEL_W-1:0]          read_select,
    input  logic                      fwd_en,
    input  logic [SEL_W-1:0]          write_select,
    input  logic [WIDTH-1:0]          writedata,
    output logic [WIDTH-1:0]          readdata
);

    always_comb begin
        readdata = regs[read_select*WIDTH +: WIDTH];
        // fwd_en already folds in reset, run and the write strobe
        if (fwd_en && (write_select == read_select)) begin
            readdata = writedata;
        end
    end

endmodule

// File: rtl/regfile_writeport.sv
// i281 general register file: storage, written flags, last-written index and two forwarding read ports.
module regfile_writeport
    import i281_pkg::*;
#(
    parameter int unsigned WIDTH    = DATA_W,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            run,
    input  logic                            regwrite_en,
    input  logic [$clog2(NUM_REGS)-1:0]     write_select,
    input  logic [WIDTH-1:0]                writedata,
    input  logic [$clog2(NUM_REGS)-1:0]     left_select,
    input  logic [$clog2(NUM_REGS)-1:0]     right_select,
    output logic [WIDTH-1:0]                reginputleft,
    output logic [WIDTH-1:0]                reginputright,
    output logic [NUM_REGS*WIDTH-1:0]       reg_dump,
    output logic [NUM_REGS-1:0]             written_flags,
    output logic [$clog2(NUM_REGS)-1:0]     last_written
);

    localparam int unsigned SEL_W = $clog2(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             wr_active;

    assign wr_active = run && regwrite_en;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            written_flags <= '0;
            last_written  <= '0;
        end else if (wr_active) begin
            regs[write_select]          <= writedata;
            written_flags[write_select] <= 1'b1;
            last_written                <= write_select;
        end
    end

    always_comb begin
        reg_dump = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_dump[i*WIDTH +: WIDTH] = regs[i];
        end
    end

    regfile_readmux #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_left (
        .regs         (reg_dump),
        .read_select  (left_select),
        .fwd_en       (reset && wr_active),
        .write_select (write_select),
        .writedata    (writedata),
        .readdata     (reginputleft)
    );

    regfile_readmux #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_right (
        .regs         (reg_dump),
        .read_select  (right_select),
        .fwd_en       (reset && wr_active),
        .write_select (write_select),
        .writedata    (writedata),
        .readdata     (reginputright)
    );

endmodule

// File: tb/tb_regfile_writeport.sv
// Directed self-checking bench for regfile_writeport.
module tb_regfile_writeport;
    import i281_pkg::*;

    logic        clock;
    logic        reset;
    logic        run;
    logic        regwrite_en;
    logic [1:0]  write_select;
    logic [7:0]  writedata;
    logic [1:0]  left_select;
    logic [1:0]  right_select;
    logic [7:0]  reginputleft;
    logic [7:0]  reginputright;
    logic [31:0] reg_dump;
    logic [3:0]  written_flags;
    logic [1:0]  last_written;

    int unsigned checks = 0;
    int unsigned errors = 0;

    regfile_writeport #(
        .WIDTH    (8),
        .NUM_REGS (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .regwrite_en   (regwrite_en),
        .write_select  (write_select),
        .writedata     (writedata),
        .left_select   (left_select),
        .right_select  (right_select),
        .reginputleft  (reginputleft),
        .reginputright (reginputright),
        .reg_dump      (reg_dump),
        .written_flags (written_flags),
        .last_written  (last_written)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input reg_idx_t sel, input logic [7:0] data);
        write_select = sel;
        writedata    = data;
        regwrite_en  = 1'b1;
        tick();
        regwrite_en  = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        run          = 1'b1;
        regwrite_en  = 1'b0;
        write_select = REG_A;
        writedata    = 8'h00;
        left_select  = REG_A;
        right_select = REG_B;

        // reset and idle
        tick();
        tick();
        check("rst_left", {24'h0, reginputleft}, 32'h0);
        reset = 1'b1;
        tick();
        check("idle_dump",  reg_dump, 32'h0);
        check("idle_flags", {28'h0, written_flags}, 32'h0);
        check("idle_left",  {24'h0, reginputleft}, 32'h0);
        check("idle_right", {24'h0, reginputright}, 32'h0);
        check("idle_last",  {30'h0, last_written}, 32'h0);

        // basic writes and reads
        write_reg(REG_A, 8'h12);
        write_reg(REG_B, 8'h34);
        write_reg(REG_C, 8'h56);
        write_reg(REG_D, 8'h78);
        check("wr_dump",  reg_dump, 32'h78563412);
        check("wr_flags", {28'h0, written_flags}, 32'hF);
        check("wr_last",  {30'h0, last_written}, 32'd3);
        left_select  = REG_B;
        right_select = REG_D;
        #1;
        check("rd_left",  {24'h0, reginputleft}, 32'h34);
        check("rd_right", {24'h0, reginputright}, 32'h78);

        // forwarding: left only, then both
        write_select = REG_B;
        writedata    = 8'hAB;
        regwrite_en  = 1'b1;
        left_select  = REG_B;
        right_select = REG_C;
        #1;
        check("fwd1_left",  {24'h0, reginputleft}, 32'hAB);
        check("fwd1_right", {24'h0, reginputright}, 32'h56);
        right_select = REG_B;
        #1;
        check("fwd2_left",  {24'h0, reginputleft}, 32'hAB);
        check("fwd2_right", {24'h0, reginputright}, 32'hAB);
        check("fwd_dump_pre", {24'h0, reg_dump[15:8]}, 32'h34);
        tick();
        regwrite_en = 1'b0;
        #1;
        check("fwd_dump_post", {24'h0, reg_dump[15:8]}, 32'hAB);
        check("fwd_last", {30'h0, last_written}, 32'd1);

        // run gating
        run          = 1'b0;
        regwrite_en  = 1'b1;
        write_select = REG_C;
        writedata    = 8'hFF;
        left_select  = REG_C;
        right_select = REG_C;
        #1;
        check("gate_left",  {24'h0, reginputleft}, 32'h56);
        check("gate_right", {24'h0, reginputright}, 32'h56);
        tick();
        tick();
        tick();
        check("gate_dump",  reg_dump, 32'h7856AB12);
        check("gate_flags", {28'h0, written_flags}, 32'hF);
        check("gate_last",  {30'h0, last_written}, 32'd1);
        run         = 1'b1;
        regwrite_en = 1'b0;

        // reset versus write collision, forwarding suppressed during reset
        reset        = 1'b0;
        regwrite_en  = 1'b1;
        write_select = REG_D;
        writedata    = 8'h99;
        left_select  = REG_D;
        #1;
        check("coll_left_pre", {24'h0, reginputleft}, 32'h78);
        tick();
        check("coll_dump",  reg_dump, 32'h0);
        check("coll_flags", {28'h0, written_flags}, 32'h0);
        check("coll_last",  {30'h0, last_written}, 32'd0);
        check("coll_left",  {24'h0, reginputleft}, 32'h0);
        reset       = 1'b1;
        regwrite_en = 1'b0;

        // reset mid-program
        write_reg(REG_A, 8'h05);
        check("mid_pre_dump",  reg_dump, 32'h00000005);
        check("mid_pre_flags", {28'h0, written_flags}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        write_reg(REG_B, 8'h07);
        check("mid_dump",  reg_dump, 32'h00000700);
        check("mid_flags", {28'h0, written_flags}, 32'h2);
        check("mid_last",  {30'h0, last_written}, 32'd1);

        // same-value rewrite sets the flag
        write_reg(REG_C, 8'h00);
        check("same_dump",  reg_dump, 32'h00000700);
        check("same_flags", {28'h0, written_flags}, 32'h6);

        // back-to-back writes to one register
        write_reg(REG_D, 8'h11);
        write_reg(REG_D, 8'h22);
        check("b2b_dump",  reg_dump, 32'h22000700);
        check("b2b_flags", {28'h0, written_flags}, 32'hE);
        check("b2b_last",  {30'h0, last_written}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
